// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel arbiter feeding a single registered output stage.
// Round-robin (mode=0) or fixed lowest-index priority (mode=1) selection;
// the output register accepts a new word whenever it is empty or draining.
module arb_mux_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gidx;
  logic [N-1:0]     grant;
  logic             found;
  logic             load;
  logic [SEL_W-1:0] ptr_next;

  assign load = !out_valid || out_ready;

  // Pick the granted channel: lowest index in fixed mode, first valid at or after ptr otherwise.
  always_comb begin
    int idx;
    found = 1'b0;
    gidx  = '0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (mode) begin
        idx = k;
      end else begin
        idx = (int'(ptr) + k) % N;
      end
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gidx  = SEL_W'(idx);
      end
    end
    if (found) begin
      grant[gidx] = 1'b1;
    end
  end

  // Accept strobes are gated by reset so nothing is taken while the block is held in reset.
  assign in_ready = (rst_n && load) ? grant : '0;

  // Pointer advances past the winner; the last channel wraps back to 0.
  always_comb begin
    ptr_next = ptr;
    if (int'(gidx) == N - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = gidx + 1'b1;
    end
  end

  // Output register and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
        out_sel   <= gidx;
        if (!mode) begin
          ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr: directed vector table on an N=4/WIDTH=32 instance,
// then random traffic against N=2 and N=16 WIDTH=8 instances with a scoreboard.
module tb_arb_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int total = 0;
  int bad   = 0;

  // N=4, WIDTH=32 instance
  logic         md4, ordy4;
  logic [3:0]   v4, r4;
  logic [127:0] d4;
  logic         o4v;
  logic [31:0]  o4d;
  logic [1:0]   o4s;

  arb_mux_rr #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(md4), .in_valid(v4), .in_data(d4),
    .in_ready(r4), .out_valid(o4v), .out_data(o4d), .out_sel(o4s), .out_ready(ordy4)
  );

  // N=2, WIDTH=8 instance
  logic         md2, ordy2;
  logic [1:0]   v2, r2;
  logic [15:0]  d2;
  logic         o2v;
  logic [7:0]   o2d;
  logic [0:0]   o2s;

  arb_mux_rr #(.WIDTH(8), .N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(md2), .in_valid(v2), .in_data(d2),
    .in_ready(r2), .out_valid(o2v), .out_data(o2d), .out_sel(o2s), .out_ready(ordy2)
  );

  // N=16, WIDTH=8 instance
  logic         md16, ordy16;
  logic [15:0]  v16, r16;
  logic [127:0] d16;
  logic         o16v;
  logic [7:0]   o16d;
  logic [3:0]   o16s;

  arb_mux_rr #(.WIDTH(8), .N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .mode(md16), .in_valid(v16), .in_data(d16),
    .in_ready(r16), .out_valid(o16v), .out_data(o16d), .out_sel(o16s), .out_ready(ordy16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: returns winning channel or -1.
  function automatic int pick(input int n, input logic [15:0] v, input int p, input bit m);
    int start;
    start = m ? 0 : p;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (start + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  typedef struct {
    bit          rstn;
    bit          md;
    logic [3:0]  v;
    bit          ordy;
    logic [3:0]  er;
    bit          eov;
    logic [31:0] ed;
    logic [1:0]  es;
  } row_t;

  row_t tbl[28];

  // Scoreboard state for the random instances (index 0: N=2, 1: N=16)
  logic [11:0] q2[$];
  logic [11:0] q16[$];
  int  mptr[2];
  bit  mov[2];

  task automatic rstep(input int k);
    int n, g, p;
    bit m, ordy, ld;
    logic [15:0]  v, rdy, exp_rdy;
    logic [127:0] d;
    logic         ov;
    logic [7:0]   od;
    logic [3:0]   os;
    logic [11:0]  front, ent;
    string        tag;
    if (k == 0) begin
      n = 2; v = {14'b0, v2}; d = {112'b0, d2}; m = md2; ordy = ordy2;
      rdy = {14'b0, r2}; ov = o2v; od = o2d; os = {3'b0, o2s}; tag = "n2";
    end else begin
      n = 16; v = v16; d = d16; m = md16; ordy = ordy16;
      rdy = r16; ov = o16v; od = o16d; os = o16s; tag = "n16";
    end
    p  = mptr[k];
    g  = pick(n, v, p, m);
    ld = !mov[k] || ordy;
    exp_rdy = (ld && g >= 0) ? (16'd1 << g) : 16'd0;
    chk({tag, "_in_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({tag, "_out_valid"}, 64'(ov), 64'(mov[k]));
    if (mov[k]) begin
      if (k == 0 && q2.size() == 0 || k == 1 && q16.size() == 0) begin
        chk({tag, "_queue_underflow"}, 64'd1, 64'd0);
      end else begin
        front = (k == 0) ? q2[0] : q16[0];
        chk({tag, "_out_data"}, 64'(od), 64'(front[7:0]));
        chk({tag, "_out_sel"}, 64'(os), 64'(front[11:8]));
        if (ordy) begin
          if (k == 0) void'(q2.pop_front()); else void'(q16.pop_front());
        end
      end
    end
    if (ld) begin
      if (g >= 0) begin
        ent = {4'(g), d[g*8 +: 8]};
        if (k == 0) q2.push_back(ent); else q16.push_back(ent);
        mov[k] = 1'b1;
        if (!m) mptr[k] = (g + 1) % n;
      end else begin
        mov[k] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    md4 = 0; ordy4 = 1; v4 = '0;
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'hA0 + i;
    md2 = 0; ordy2 = 1; v2 = '0; d2 = '0;
    md16 = 0; ordy16 = 1; v16 = '0; d16 = '0;

    //          rstn md v     ordy er    eov ed        es
    tbl[0]  = '{0, 0, 4'hF, 1, 4'h0, 0, 32'h00, 2'd0};
    tbl[1]  = '{1, 0, 4'hF, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[2]  = '{1, 0, 4'hF, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[3]  = '{1, 0, 4'hF, 1, 4'h4, 1, 32'hA2, 2'd2};
    tbl[4]  = '{1, 0, 4'hF, 1, 4'h8, 1, 32'hA3, 2'd3};
    tbl[5]  = '{1, 0, 4'hF, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[6]  = '{1, 0, 4'hF, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[7]  = '{1, 0, 4'h4, 1, 4'h4, 1, 32'hA2, 2'd2};
    tbl[8]  = '{1, 0, 4'h1, 0, 4'h0, 1, 32'hA2, 2'd2};
    tbl[9]  = '{1, 0, 4'h1, 0, 4'h0, 1, 32'hA2, 2'd2};
    tbl[10] = '{1, 0, 4'h1, 0, 4'h0, 1, 32'hA2, 2'd2};
    tbl[11] = '{1, 0, 4'h1, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[12] = '{1, 1, 4'hA, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[13] = '{1, 1, 4'hA, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[14] = '{1, 1, 4'hA, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[15] = '{1, 0, 4'h4, 1, 4'h4, 1, 32'hA2, 2'd2};
    tbl[16] = '{1, 0, 4'h3, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[17] = '{1, 0, 4'h3, 1, 4'h2, 1, 32'hA1, 2'd1};
    tbl[18] = '{1, 0, 4'h0, 1, 4'h0, 0, 32'hA1, 2'd1};
    tbl[19] = '{1, 1, 4'hC, 1, 4'h4, 1, 32'hA2, 2'd2};
    tbl[20] = '{1, 0, 4'hC, 1, 4'h4, 1, 32'hA2, 2'd2};
    tbl[21] = '{1, 0, 4'hC, 1, 4'h8, 1, 32'hA3, 2'd3};
    tbl[22] = '{1, 0, 4'hF, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[23] = '{0, 0, 4'hF, 1, 4'h0, 0, 32'h00, 2'd0};
    tbl[24] = '{1, 0, 4'hF, 1, 4'h1, 1, 32'hA0, 2'd0};
    tbl[25] = '{1, 0, 4'hF, 0, 4'h0, 1, 32'hA0, 2'd0};
    tbl[26] = '{1, 0, 4'h0, 1, 4'h0, 0, 32'hA0, 2'd0};
    tbl[27] = '{1, 0, 4'h2, 0, 4'h2, 1, 32'hA1, 2'd1};

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rstn; md4 = tbl[i].md; v4 = tbl[i].v; ordy4 = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", i), 64'(r4), 64'(tbl[i].er));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_valid", i), 64'(o4v), 64'(tbl[i].eov));
      chk($sformatf("row%0d_out_data", i), 64'(o4d), 64'(tbl[i].ed));
      chk($sformatf("row%0d_out_sel", i), 64'(o4s), 64'(tbl[i].es));
    end

    // Random traffic on the N=2 and N=16 instances after a fresh reset.
    @(negedge clk);
    rst_n = 1'b0; v4 = '0;
    @(posedge clk);
    #1;
    mptr[0] = 0; mptr[1] = 0; mov[0] = 0; mov[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n  = 1'b1;
      v2     = 2'($urandom);
      d2     = 16'($urandom);
      ordy2  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md2 = ~md2;
      v16    = 16'($urandom) & 16'($urandom);
      d16    = {$urandom, $urandom, $urandom, $urandom};
      ordy16 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md16 = ~md16;
      #1;
      rstep(0);
      rstep(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
